fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage_if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, reset/bubble encodings and the
// fetch-stage state type used by fetch, hazard and decode.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC  = 16'h0000;
    localparam logic [DATA_W-1:0] DEF_NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read handshake between the fetch stage and the memory.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, else bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_pc_plus1,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus1,
    output logic              o_valid
);

    // Register update with flush > hold > load > bubble priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_instr    <= NOP_INSTR;
            o_pc       <= '0;
            o_pc_plus1 <= '0;
            o_valid    <= 1'b0;
        end else if (i_flush) begin
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_hold) begin
            o_instr <= o_instr;
            o_valid <= o_valid;
        end else if (i_load) begin
            o_instr    <= i_instr;
            o_pc       <= i_pc;
            o_pc_plus1 <= i_pc_plus1;
            o_valid    <= 1'b1;
        end else begin
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, redirect handling across an in-flight
// memory read, and the IF/ID register feeding decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [DATA_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master     imem,
    output logic [DATA_W-1:0] instr_d,
    output logic [ADDR_W-1:0] pc_d,
    output logic [ADDR_W-1:0] pc_plus1_d,
    output logic              valid_d,
    output logic              fetch_busy
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc_f;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_pending_pc;
    logic [ADDR_W-1:0] w_pending_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_load;

    // Request is always live out of reset; it drops the moment reset rises.
    assign imem.imem_req  = ~reset;
    assign imem.imem_addr = r_pc_f;
    assign fetch_busy     = imem.imem_req & ~imem.imem_ready;

    assign w_pc_inc = r_pc_f + ADDR_W'(1);
    assign w_load   = (r_state == RUN) & imem.imem_ready & ~stall_f;

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc_f       <= RESET_PC;
            r_pending_pc <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc_f       <= w_pc_nxt;
            r_pending_pc <= w_pending_nxt;
        end
    end

    // Next-state: a redirect during a stalled read parks in DRAIN so the
    // address stays stable until the memory completes the old request.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc_f;
        w_pending_nxt = r_pending_pc;
        unique case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    if (!imem.imem_ready) begin
                        w_pending_nxt = redirect_pc;
                        w_state_nxt   = DRAIN;
                    end else begin
                        w_pc_nxt = redirect_pc;
                    end
                end else if (imem.imem_ready && !stall_f) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    w_pending_nxt = redirect_pc;
                end
                if (imem.imem_ready) begin
                    // Latest redirect wins, including one arriving this cycle.
                    w_pc_nxt    = redirect_valid ? redirect_pc : r_pending_pc;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (redirect_valid),
        .i_hold     (stall_d),
        .i_load     (w_load),
        .i_instr    (imem.imem_rdata),
        .i_pc       (r_pc_f),
        .i_pc_plus1 (w_pc_inc),
        .o_instr    (instr_d),
        .o_pc       (pc_d),
        .o_pc_plus1 (pc_plus1_d),
        .o_valid    (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/memory-latency traffic against a transaction-level model.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] instr_d;
    logic [15:0] pc_d;
    logic [15:0] pc_plus1_d;
    logic        valid_d;
    logic        fetch_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: address the core is fetching, an optional parked
    // redirect target, and the contents of the IF/ID register.
    logic [15:0] m_pc;
    logic        m_parked;
    logic [15:0] m_target;
    logic [15:0] m_instr;
    logic [15:0] m_pc_d;
    logic [15:0] m_pc1;
    logic        m_valid;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    // Memory content: each word holds its own address plus 0x1000.
    assign bus.imem_rdata = bus.imem_addr + 16'h1000;

    fetch_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus.master),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus1_d     (pc_plus1_d),
        .valid_d        (valid_d),
        .fetch_busy     (fetch_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_parked = 1'b0;
        m_target = 16'h0000;
        m_instr  = 16'h0000;
        m_pc_d   = 16'h0000;
        m_pc1    = 16'h0000;
        m_valid  = 1'b0;
    endtask

    // Compare every DUT output against the model mid-cycle, then advance the
    // model by one clock using the applied inputs.
    task automatic cycle(input logic sf, input logic sd, input logic rv,
                         input logic [15:0] rp, input logic rdy);
        logic done;
        stall_f        = sf;
        stall_d        = sd;
        redirect_valid = rv;
        redirect_pc    = rp;
        bus.imem_ready = rdy;
        #1;
        check_eq("imem_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("imem_addr", {16'd0, bus.imem_addr}, {16'd0, m_pc});
        check_eq("fetch_busy", {31'd0, fetch_busy}, {31'd0, ~rdy});
        check_eq("instr_d", {16'd0, instr_d}, {16'd0, m_instr});
        check_eq("pc_d", {16'd0, pc_d}, {16'd0, m_pc_d});
        check_eq("pc_plus1_d", {16'd0, pc_plus1_d}, {16'd0, m_pc1});
        check_eq("valid_d", {31'd0, valid_d}, {31'd0, m_valid});

        done = rdy;
        // IF/ID contents after the edge.
        if (rv) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end else if (sd) begin
            // held
        end else if (!m_parked && done && !sf) begin
            m_instr = m_pc + 16'h1000;
            m_pc_d  = m_pc;
            m_pc1   = m_pc + 16'd1;
            m_valid = 1'b1;
        end else begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
        end
        // Fetch address after the edge.
        if (m_parked) begin
            if (rv) m_target = rp;
            if (done) begin
                m_pc     = m_target;
                m_parked = 1'b0;
            end
        end else if (rv) begin
            if (done) m_pc = rp;
            else begin
                m_parked = 1'b1;
                m_target = rp;
            end
        end else if (done && !sf) begin
            m_pc = m_pc + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, confirm outputs clear at once, then release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("rst_addr", {16'd0, bus.imem_addr}, 32'h0000);
        check_eq("rst_busy", {31'd0, fetch_busy}, 32'd0);
        check_eq("rst_instr", {16'd0, instr_d}, 32'h0000);
        check_eq("rst_pc_d", {16'd0, pc_d}, 32'h0000);
        check_eq("rst_pc1", {16'd0, pc_plus1_d}, 32'h0000);
        check_eq("rst_valid", {31'd0, valid_d}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        bus.imem_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait streaming.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t1_instr", {16'd0, instr_d}, 32'h1002);
        check_eq("t1_pc_d", {16'd0, pc_d}, 32'h0002);
        check_eq("t1_valid", {31'd0, valid_d}, 32'd1);

        // Full stall at pc_f=5.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        check_eq("t2_addr", {16'd0, bus.imem_addr}, 32'h0005);
        check_eq("t2_pc_d", {16'd0, pc_d}, 32'h0004);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t2_resume", {16'd0, pc_d}, 32'h0005);

        // stall_f only at pc_f=7: one bubble.
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t3_bubble_v", {31'd0, valid_d}, 32'd0);
        check_eq("t3_bubble_i", {16'd0, instr_d}, 32'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t3_pc_d", {16'd0, pc_d}, 32'h0007);

        // Zero-wait redirect overrides stall_d.
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
        check_eq("t4_bubble", {31'd0, valid_d}, 32'd0);
        check_eq("t4_addr", {16'd0, bus.imem_addr}, 32'h0040);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t4_pc_d", {16'd0, pc_d}, 32'h0040);

        // Redirect during a slow read, then a second redirect while draining.
        cycle(1'b0, 1'b0, 1'b1, 16'h0012, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0);
        check_eq("t5_hold1", {16'd0, bus.imem_addr}, 32'h0012);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        check_eq("t5_hold2", {16'd0, bus.imem_addr}, 32'h0012);
        cycle(1'b0, 1'b0, 1'b1, 16'h00A0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t5_drop", {31'd0, valid_d}, 32'd0);
        check_eq("t5_addr", {16'd0, bus.imem_addr}, 32'h00A0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t5_pc_d", {16'd0, pc_d}, 32'h00A0);

        // PC wrap.
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        check_eq("t6_pc_d", {16'd0, pc_d}, 32'hFFFF);
        check_eq("t6_pc1", {16'd0, pc_plus1_d}, 32'h0000);
        check_eq("t6_addr", {16'd0, bus.imem_addr}, 32'h0000);

        // Reset in the middle of a wait.
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        bus.imem_ready = 1'b0;
        #2;
        do_reset();
        check_eq("t6_rst_pc", {16'd0, bus.imem_addr}, 32'h0000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 8), 16'($urandom),
                  ($urandom_range(0, 99) < 65));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
